// File: rtl/logic_issue_stage_if.sv
// Operand/writeback bundle between decode, the logic issue stage, the
// combinational logical unit and the register-file write port.
interface logic_issue_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            In_Valid;
    logic            In_Ready;
    logic [2:0]      In_Funct3;
    logic [XLEN-1:0] In_Rs1;
    logic [XLEN-1:0] In_Rs2;
    logic [REGW-1:0] In_Rd;
    logic            Flush;
    logic [XLEN-1:0] Src1;
    logic [XLEN-1:0] Src2;
    logic [1:0]      funct3_1_0;
    logic            En;
    logic [XLEN-1:0] Result;
    logic            Wb_Valid;
    logic            Wb_Ready;
    logic [REGW-1:0] Wb_Rd;
    logic [XLEN-1:0] Wb_Data;
    logic            Illegal;

    // The issue stage itself
    modport slave (
        input  In_Valid, In_Funct3, In_Rs1, In_Rs2, In_Rd, Flush, Result, Wb_Ready,
        output In_Ready, Src1, Src2, funct3_1_0, En, Wb_Valid, Wb_Rd, Wb_Data, Illegal
    );

    // Surroundings: decode, logical unit and register file
    modport master (
        output In_Valid, In_Funct3, In_Rs1, In_Rs2, In_Rd, Flush, Result, Wb_Ready,
        input  In_Ready, Src1, Src2, funct3_1_0, En, Wb_Valid, Wb_Rd, Wb_Data, Illegal
    );
endinterface

// File: rtl/logic_issue_stage.sv
// Two-stage issue/writeback pipeline feeding the combinational logical unit
// (XOR/OR/AND) and holding its result for the register file.
module logic_issue_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic CLK,
    input logic RST,
    logic_issue_stage_if.slave bus
);
    logic            s1_valid;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic [1:0]      op_q;
    logic [REGW-1:0] s1_rd;
    logic            wb_valid;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal_q;

    logic in_ready;
    logic accept;
    logic legal;
    logic s2_load;

    // Only funct3 100 (XOR), 110 (OR), 111 (AND) belong to this unit
    assign legal    = bus.In_Funct3[2] & (bus.In_Funct3[1] | ~bus.In_Funct3[0]);
    assign in_ready = ~s1_valid | ~wb_valid | bus.Wb_Ready;
    assign accept   = bus.In_Valid & in_ready;
    assign s2_load  = s1_valid & (~wb_valid | bus.Wb_Ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            op_q      <= 2'b00;
            s1_rd     <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            illegal_q <= 1'b0;
        end else if (bus.Flush) begin
            // Kill valids only; data registers keep their contents
            s1_valid  <= 1'b0;
            wb_valid  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & ~legal;

            if (accept && legal) begin
                s1_valid <= 1'b1;
                src1_q   <= bus.In_Rs1;
                src2_q   <= bus.In_Rs2;
                op_q     <= bus.In_Funct3[1:0];
                s1_rd    <= bus.In_Rd;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                wb_valid <= 1'b1;
                wb_data  <= bus.Result;
                wb_rd    <= s1_rd;
            end else if (wb_valid && bus.Wb_Ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign bus.In_Ready   = in_ready;
    assign bus.Src1       = src1_q;
    assign bus.Src2       = src2_q;
    assign bus.funct3_1_0 = op_q;
    assign bus.En         = s1_valid;
    assign bus.Wb_Valid   = wb_valid;
    assign bus.Wb_Rd      = wb_rd;
    assign bus.Wb_Data    = wb_data;
    assign bus.Illegal    = illegal_q;
endmodule
